// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//   Conditions two raw mechanical switch inputs for downstream logic.
//   Each input is synchronised through two flops. A new level is accepted only
//   after the synchronised input has disagreed with the current clean level
//   for DEBOUNCE_CYCLES consecutive clocks. The block emits clean levels,
//   one-cycle edge pulses and the AND of the two clean levels.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing clocks needed to accept a level (>= 1)
//   CNT_W            counter width, derived from DEBOUNCE_CYCLES
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   in_a     raw switch A (asynchronous, may bounce)
//   in_b     raw switch B (asynchronous, may bounce)
//   sw_a     debounced level of A
//   sw_b     debounced level of B
//   rise_a   one-cycle pulse when sw_a goes 0->1
//   fall_a   one-cycle pulse when sw_a goes 1->0
//   rise_b   one-cycle pulse when sw_b goes 0->1
//   fall_b   one-cycle pulse when sw_b goes 1->0
//   out      sw_a & sw_b
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_a,
  input  logic in_b,
  output logic sw_a,
  output logic sw_b,
  output logic rise_a,
  output logic fall_a,
  output logic rise_b,
  output logic fall_b,
  output logic out
);

  localparam int unsigned NCH = 2;

  // Count value at which the disagreement has lasted DEBOUNCE_CYCLES clocks.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] lvl;
  logic [NCH-1:0] rise_r;
  logic [NCH-1:0] fall_r;
  logic [CNT_W-1:0] cnt [NCH];

  // Bit 0 is channel A, bit 1 is channel B.
  assign raw = {in_b, in_a};

  // Two-flop synchroniser plus per-channel stability filter and pulse regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      lvl    <= '0;
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1     <= raw;
      s2     <= s1;
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == lvl[i]) begin
          // Any cycle of agreement restarts the stability window.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // Disagreement held long enough: accept the new level.
          lvl[i]    <= s2[i];
          cnt[i]    <= '0;
          rise_r[i] <= s2[i];
          fall_r[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_a   = lvl[0];
  assign sw_b   = lvl[1];
  assign rise_a = rise_r[0];
  assign fall_a = fall_r[0];
  assign rise_b = rise_r[1];
  assign fall_b = fall_r[1];

  // Combinational AND of the registered clean levels.
  assign out = lvl[0] & lvl[1];

endmodule
